// File: rtl/l1_tag_lookup.sv
// rtl/l1_tag_lookup.sv - set-associative L1 tag lookup with fill/invalidate, victim select and valid sweep
// Optional feature macro: L1_TAG_LOOKUP_PLRU_EN (per-set tree pseudo-LRU instead of global round-robin)
module l1_tag_lookup #(
  parameter  int ADDR_WIDTH      = 32,
  parameter  int WAY_NUMBER      = 4,
  parameter  int SET_NUMBER      = 64,
  parameter  int BLOCK_SIZE      = 32,
  localparam int OFS_W           = $clog2(BLOCK_SIZE) + 2,
  localparam int IDX_W           = $clog2(SET_NUMBER),
  localparam int WAY_W           = $clog2(WAY_NUMBER),
  localparam int TAG_WIDTH       = ADDR_WIDTH - IDX_W - OFS_W,
  localparam int DATA_ADDR_WIDTH = WAY_W + IDX_W + OFS_W - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_req_val,
  output logic                       core_req_rdy,
  input  logic [ADDR_WIDTH-1:0]      core_req_addr,
  output logic                       rsp_val,
  output logic                       rsp_hit,
  output logic [WAY_W-1:0]           rsp_way,
  output logic [DATA_ADDR_WIDTH-1:0] rsp_data_addr,
  input  logic                       fill_val,
  output logic                       fill_rdy,
  input  logic [ADDR_WIDTH-1:0]      fill_addr,
  input  logic [WAY_W-1:0]           fill_way,
  input  logic                       inv_val,
  input  logic [ADDR_WIDTH-1:0]      inv_addr,
  input  logic                       flush_val,
  output logic                       busy
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] sweep_idx;
  logic             sweep_en;

  // Tag RAM is never cleared; validity lives in a separate per-set way vector.
  logic [TAG_WIDTH-1:0]  tag_ram   [WAY_NUMBER][SET_NUMBER];
  logic [WAY_NUMBER-1:0] valid_ram [SET_NUMBER];

  logic [TAG_WIDTH-1:0]  req_tag,  fill_tag,  inv_tag;
  logic [IDX_W-1:0]      req_idx,  fill_idx,  inv_idx;
  logic [OFS_W-3:0]      req_word;

  logic                  req_go, fill_go, inv_go;
  logic [WAY_NUMBER-1:0] inv_clr;

  logic [TAG_WIDTH-1:0]  rd_tag   [WAY_NUMBER];
  logic [WAY_NUMBER-1:0] rd_valid;
  logic [WAY_NUMBER-1:0] hit_vec;
  logic                  lk_hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      free_way;
  logic [WAY_W-1:0]      policy_way;
  logic [WAY_W-1:0]      lk_way;

  logic                  unused_addr_bits;

  assign req_tag  = core_req_addr[ADDR_WIDTH-1:IDX_W+OFS_W];
  assign req_idx  = core_req_addr[IDX_W+OFS_W-1:OFS_W];
  assign req_word = core_req_addr[OFS_W-1:2];
  assign fill_tag = fill_addr[ADDR_WIDTH-1:IDX_W+OFS_W];
  assign fill_idx = fill_addr[IDX_W+OFS_W-1:OFS_W];
  assign inv_tag  = inv_addr[ADDR_WIDTH-1:IDX_W+OFS_W];
  assign inv_idx  = inv_addr[IDX_W+OFS_W-1:OFS_W];

  assign unused_addr_bits = ^{fill_addr[OFS_W-1:0], inv_addr[OFS_W-1:0]};

  assign req_go  = core_req_val && core_req_rdy;
  assign fill_go = fill_val && fill_rdy;
  assign inv_go  = inv_val && fill_rdy;

  // State register; reset always restarts the valid sweep from set 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Sweep pointer wraps back to 0 at the end of each sweep, ready for the next flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sweep_idx <= '0;
    else if (sweep_en) sweep_idx <= sweep_idx + 1'b1;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt    = state;
    core_req_rdy = 1'b0;
    fill_rdy     = 1'b0;
    busy         = 1'b0;
    sweep_en     = 1'b0;
    case (state)
      ST_INIT, ST_FLUSH: begin
        busy     = 1'b1;
        sweep_en = 1'b1;
        if (sweep_idx == IDX_W'(SET_NUMBER - 1)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        core_req_rdy = 1'b1;
        fill_rdy     = 1'b1;
        if (flush_val) state_nxt = ST_FLUSH;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Invalidate targets every matching way, except the way a same-cycle fill writes.
  always_comb begin
    inv_clr = '0;
    for (int w = 0; w < WAY_NUMBER; w++) begin
      inv_clr[w] = inv_go && (tag_ram[w][inv_idx] == inv_tag) &&
                   !(fill_go && (fill_idx == inv_idx) && (fill_way == WAY_W'(w)));
    end
  end

  // Tag/valid RAM writes: sweep clears a whole set, otherwise invalidate then fill.
  always_ff @(posedge clk) begin
    if (sweep_en) begin
      valid_ram[sweep_idx] <= '0;
    end else begin
      for (int w = 0; w < WAY_NUMBER; w++) begin
        if (inv_clr[w]) valid_ram[inv_idx][w] <= 1'b0;
      end
      if (fill_go) begin
        valid_ram[fill_idx][fill_way] <= 1'b1;
        tag_ram[fill_way][fill_idx]   <= fill_tag;
      end
    end
  end

  // Stage 0 read, with same-cycle fill/invalidate at the read index forwarded in.
  always_comb begin
    rd_valid = valid_ram[req_idx];
    for (int w = 0; w < WAY_NUMBER; w++) begin
      rd_tag[w] = tag_ram[w][req_idx];
      if (inv_clr[w] && (inv_idx == req_idx)) rd_valid[w] = 1'b0;
      if (fill_go && (fill_idx == req_idx) && (fill_way == WAY_W'(w))) begin
        rd_tag[w]   = fill_tag;
        rd_valid[w] = 1'b1;
      end
    end
  end

  // Tag compare; lowest matching way wins and lowest invalid way is preferred as victim.
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    for (int w = 0; w < WAY_NUMBER; w++) begin
      hit_vec[w] = rd_valid[w] && (rd_tag[w] == req_tag);
    end
    for (int w = WAY_NUMBER - 1; w >= 0; w--) begin
      if (hit_vec[w])   hit_way  = WAY_W'(w);
      if (!rd_valid[w]) free_way = WAY_W'(w);
    end
    lk_hit = |hit_vec;
    if (lk_hit)         lk_way = hit_way;
    else if (&rd_valid) lk_way = policy_way;
    else                lk_way = free_way;
  end

  // Response register; fields hold their last value between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_val       <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_way       <= '0;
      rsp_data_addr <= '0;
    end else begin
      rsp_val <= req_go;
      if (req_go) begin
        rsp_hit       <= lk_hit;
        rsp_way       <= lk_way;
        rsp_data_addr <= {lk_way, req_idx, req_word};
      end
    end
  end

`ifdef L1_TAG_LOOKUP_PLRU_EN
  // Tree node n has children 2n+1 / 2n+2; a set bit steers the victim to the right half.
  logic [WAY_NUMBER-2:0] plru [SET_NUMBER];

  function automatic logic [WAY_NUMBER-2:0] plru_touch(input logic [WAY_NUMBER-2:0] bits,
                                                      input logic [WAY_W-1:0]      way);
    logic [WAY_NUMBER-2:0] res;
    int                    node;
    res  = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      res[node] = ~way[WAY_W-1-l];
      node      = 2 * node + 1 + int'(way[WAY_W-1-l]);
    end
    return res;
  endfunction

  // Walk the tree of the requested set to find the pseudo-LRU way.
  always_comb begin
    int node;
    node       = 0;
    policy_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      policy_way[WAY_W-1-l] = plru[req_idx][node];
      node = 2 * node + 1 + int'(plru[req_idx][node]);
    end
  end

  // Hit and fill both touch the tree; on the same set the fill is applied last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SET_NUMBER; s++) plru[s] <= '0;
    end else if (sweep_en) begin
      plru[sweep_idx] <= '0;
    end else begin
      if (req_go && lk_hit) begin
        if (fill_go && (fill_idx == req_idx))
          plru[req_idx] <= plru_touch(plru_touch(plru[req_idx], lk_way), fill_way);
        else
          plru[req_idx] <= plru_touch(plru[req_idx], lk_way);
      end
      if (fill_go && !(req_go && lk_hit && (fill_idx == req_idx)))
        plru[fill_idx] <= plru_touch(plru[fill_idx], fill_way);
    end
  end
`else
  logic [WAY_W-1:0] rr_cnt;

  // Global round-robin pointer advanced by every accepted fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rr_cnt <= '0;
    else if (fill_go) rr_cnt <= rr_cnt + 1'b1;
  end

  assign policy_way = rr_cnt;
`endif

endmodule
